// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl
// Sequencing controller for the small processor datapath (program counter,
// address select, RAM and accumulator). Each instruction runs through a
// FETCH / DATA / WB sequence, and a run covers the whole RAM address space.
// In FETCH the RAM address is the program counter. In DATA it is the
// instruction word just fetched, and the word read there goes into the
// accumulator.
//
// Optional feature macro: SINGLE_STEP_EN
//   When defined, an input 'step' and a PAUSE state are added. After each
//   write-back the controller waits in PAUSE until 'step' (continue) or
//   'halt_req' (stop) is seen. If both arrive together, the halt wins.
//
// Parameters:
//   ADDR_W   RAM address width (pc, mem_addr)
//   DATA_W   RAM data width (ir, acc); must be >= ADDR_W
//   MEM_LAT  cycles the address is held before read data is sampled (1..7)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin or resume execution (only looked at in IDLE)
//   halt_req   stop after the current instruction (only looked at in WB)
//   step       continue from PAUSE (SINGLE_STEP_EN only)
//   mem_rdata  combinational RAM read data
//   mem_addr   RAM address
//   status     0 = fetch phase, 1 = data phase
//   pc         program counter
//   ir         instruction register
//   acc        accumulator
//   acc_load   high in the cycle whose closing edge loads acc
//   busy       high while an instruction is in progress
//   done       one-cycle pulse in the first IDLE cycle after a run ends
module fetch_exec_ctrl #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 2,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              status,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              acc_load,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_WB
`ifdef SINGLE_STEP_EN
    ,S_PAUSE
`endif
  } state_t;

  // The final wait-counter value of a FETCH or DATA phase.
  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              status_q, status_d;
  logic              acc_load_q, acc_load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state logic. All outputs are registered, so each output is
  // computed here from the state the machine is about to enter. The
  // registered value then matches the state shown in the same cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_q == WAIT_LAST) begin
          ir_d    = mem_rdata;
          state_d = S_DATA;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_DATA: begin
        if (wait_q == WAIT_LAST) begin
          acc_d   = mem_rdata;
          state_d = S_WB;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_WB: begin
        pc_d = pc_q + ADDR_W'(1);
        // A pc wrap ends the program. A halt request also ends the run,
        // but pc is left pointing at the next instruction.
        if ((&pc_q) || halt_req) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
`ifdef SINGLE_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (halt_req) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (step) begin
          state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Every phase counts its wait cycles from zero.
    if (state_d != state_q) wait_d = 3'd0;

    mem_addr_d = (state_d == S_DATA) ? ir_d[ADDR_W-1:0] : pc_d;
    status_d   = (state_d == S_DATA);
    acc_load_d = (state_d == S_DATA) && (wait_d == WAIT_LAST);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers. Reset overrides everything, including an
  // instruction that is only partly done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 3'd0;
      pc_q       <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      mem_addr_q <= '0;
      status_q   <= 1'b0;
      acc_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      mem_addr_q <= mem_addr_d;
      status_q   <= status_d;
      acc_load_q <= acc_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign status   = status_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign acc      = acc_q;
  assign acc_load = acc_load_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// tb_fetch_exec_ctrl
// Directed bench for fetch_exec_ctrl. dutA uses MEM_LAT=1 and dutB uses
// MEM_LAT=3. Both read the same four-word program from a combinational RAM
// model. dutB's read data can be inverted during the cycles in which it
// must not be sampled.
module tb_fetch_exec_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       startA, startB, haltReq;
  logic       garbleB;
  logic [1:0] ram [4];
  logic [1:0] rdataA, rdataB;
  logic [1:0] addrA, addrB, pcA, pcB, irA, irB, accA, accB;
  logic       statusA, statusB, accLoadA, accLoadB;
  logic       busyA, busyB, doneA, doneB;
`ifdef SINGLE_STEP_EN
  logic       stepA, stepB;
`endif

  int checks = 0;
  int errors = 0;
  int accLoadCount;

  // Program: ir sequence 10,11,01,00 gives acc sequence 01,00,11,10.
  int expAddrA [13] = '{0, 2, 0, 1, 3, 1, 2, 1, 2, 3, 0, 3, 0};
  int expAcc   [4]  = '{1, 0, 3, 2};
  int expIr    [4]  = '{2, 3, 1, 0};

  always #5 clk = ~clk;

  assign rdataA = ram[addrA];
  assign rdataB = garbleB ? ~ram[addrB] : ram[addrB];

  fetch_exec_ctrl #(.ADDR_W(2), .DATA_W(2), .MEM_LAT(1)) dutA (
    .clk(clk), .reset(reset), .start(startA), .halt_req(haltReq),
`ifdef SINGLE_STEP_EN
    .step(stepA),
`endif
    .mem_rdata(rdataA), .mem_addr(addrA), .status(statusA), .pc(pcA),
    .ir(irA), .acc(accA), .acc_load(accLoadA), .busy(busyA), .done(doneA)
  );

  fetch_exec_ctrl #(.ADDR_W(2), .DATA_W(2), .MEM_LAT(3)) dutB (
    .clk(clk), .reset(reset), .start(startB), .halt_req(haltReq),
`ifdef SINGLE_STEP_EN
    .step(stepB),
`endif
    .mem_rdata(rdataB), .mem_addr(addrB), .status(statusB), .pc(pcB),
    .ir(irB), .acc(accB), .acc_load(accLoadB), .busy(busyB), .done(doneB)
  );

  // Drives the inputs for the current cycle, then moves to 1 ns after the
  // next rising edge, where the registered outputs are stable.
  task automatic applyStimulus(input logic rst, input logic stA,
                               input logic stB, input logic hlt);
    reset   = rst;
    startA  = stA;
    startB  = stB;
    haltReq = hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    ram[0] = 2'b10; ram[1] = 2'b11; ram[2] = 2'b01; ram[3] = 2'b00;
    garbleB = 1'b0;
    reset = 1'b1; startA = 1'b0; startB = 1'b0; haltReq = 1'b0;
`ifdef SINGLE_STEP_EN
    stepA = 1'b0; stepB = 1'b0;
`endif
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset values on both instances.
    checkOutput("rst_pcA", pcA, 0);
    checkOutput("rst_irA", irA, 0);
    checkOutput("rst_accA", accA, 0);
    checkOutput("rst_addrA", addrA, 0);
    checkOutput("rst_statusA", statusA, 0);
    checkOutput("rst_accLoadA", accLoadA, 0);
    checkOutput("rst_busyA", busyA, 0);
    checkOutput("rst_doneA", doneA, 0);
    checkOutput("rst_busyB", busyB, 0);
    checkOutput("rst_pcB", pcB, 0);

`ifndef SINGLE_STEP_EN
    // Full run on dutA: start in cycle T, busy T+1..T+12, done at T+13.
    // start is raised again in the done cycle to begin the next run.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    accLoadCount = 0;
    for (int k = 1; k <= 13; k++) begin
      checkOutput($sformatf("run_busy_%0d", k), busyA, (k <= 12));
      checkOutput($sformatf("run_done_%0d", k), doneA, (k == 13));
      checkOutput($sformatf("run_addr_%0d", k), addrA, expAddrA[k-1]);
      checkOutput($sformatf("run_status_%0d", k), statusA,
                  (k <= 12) && ((k - 1) % 3 == 1));
      checkOutput($sformatf("run_accload_%0d", k), accLoadA,
                  (k <= 12) && ((k - 1) % 3 == 1));
      if (accLoadA === 1'b1) accLoadCount++;
      if ((k <= 12) && ((k - 1) % 3 == 2)) begin
        checkOutput($sformatf("run_acc_%0d", k), accA, expAcc[(k-1)/3]);
        checkOutput($sformatf("run_ir_%0d", k), irA, expIr[(k-1)/3]);
        checkOutput($sformatf("run_pc_%0d", k), pcA, (k - 1) / 3);
      end
      if (k == 13) checkOutput("run_pc_end", pcA, 0);
      applyStimulus(1'b0, (k == 13), 1'b0, 1'b0);
    end
    checkOutput("run_accload_total", accLoadCount, 4);

    // Halt: this run started in the done cycle (T'), halt_req from T'+2.
    checkOutput("halt_busy_T1", busyA, 1);
    checkOutput("halt_addr_T1", addrA, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("halt_wb_status", statusA, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("halt_done", doneA, 1);
    checkOutput("halt_busy", busyA, 0);
    checkOutput("halt_pc", pcA, 1);
    checkOutput("halt_acc", accA, 1);
    checkOutput("halt_addr", addrA, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_done_gone", doneA, 0);
    checkOutput("halt_pc_hold", pcA, 1);
    checkOutput("halt_acc_hold", accA, 1);

    // Resume from pc=1: three instructions, done after 9 busy cycles.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) checkOutput("resume_addr", addrA, 1);
      checkOutput($sformatf("resume_busy_%0d", i), busyA, (i <= 9));
      checkOutput($sformatf("resume_done_%0d", i), doneA, (i == 10));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("resume_acc", accA, 2);
    checkOutput("resume_pc", pcA, 0);
    checkOutput("resume_ir", irA, 0);

    // start held during busy is ignored; reset lands in DATA of instr 2.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        checkOutput("busystart_pc1", pcA, 1);
        checkOutput("busystart_addr1", addrA, 1);
      end
      if (k == 7) begin
        checkOutput("busystart_pc2", pcA, 2);
        checkOutput("busystart_addr2", addrA, 2);
      end
      if (k == 8) begin
        checkOutput("midrst_status_before", statusA, 1);
        checkOutput("midrst_addr_before", addrA, 1);
      end
      applyStimulus((k == 8), (k <= 5), 1'b0, 1'b0);
    end
    checkOutput("midrst_pc", pcA, 0);
    checkOutput("midrst_ir", irA, 0);
    checkOutput("midrst_acc", accA, 0);
    checkOutput("midrst_addr", addrA, 0);
    checkOutput("midrst_status", statusA, 0);
    checkOutput("midrst_accload", accLoadA, 0);
    checkOutput("midrst_busy", busyA, 0);
    checkOutput("midrst_done", doneA, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_idle", busyA, 0);

    // dutB (MEM_LAT=3): 7 cycles per instruction, 28 busy cycles. Read
    // data is inverted in every FETCH/DATA cycle except the sampling one.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 29; k++) begin
      garbleB = (k <= 28) && (((k - 1) % 7 == 0) || ((k - 1) % 7 == 1) ||
                              ((k - 1) % 7 == 3) || ((k - 1) % 7 == 4));
      checkOutput($sformatf("lat_busy_%0d", k), busyB, (k <= 28));
      checkOutput($sformatf("lat_done_%0d", k), doneB, (k == 29));
      if (k <= 28) begin
        checkOutput($sformatf("lat_status_%0d", k), statusB,
                    ((k - 1) % 7 >= 3) && ((k - 1) % 7 <= 5));
        checkOutput($sformatf("lat_accload_%0d", k), accLoadB,
                    ((k - 1) % 7 == 5));
        if ((k - 1) % 7 == 6) begin
          checkOutput($sformatf("lat_acc_%0d", k), accB, expAcc[(k-1)/7]);
          checkOutput($sformatf("lat_ir_%0d", k), irB, expIr[(k-1)/7]);
        end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    garbleB = 1'b0;
    checkOutput("lat_pc_end", pcB, 0);
`else
    // Single-step on dutA: PAUSE after each WB until step or halt.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      if (k == 4 || k == 5 || k == 9) begin
        checkOutput($sformatf("pause_busy_%0d", k), busyA, 1);
        checkOutput($sformatf("pause_status_%0d", k), statusA, 0);
        checkOutput($sformatf("pause_addr_%0d", k), addrA, (k == 9) ? 2 : 1);
      end
      if (k == 4) checkOutput("pause_acc", accA, 1);
      if (k == 6) checkOutput("step_fetch_addr", addrA, 1);
      if (k == 7) checkOutput("step_data_addr", addrA, 3);
      if (k == 10) begin
        checkOutput("pause_halt_done", doneA, 1);
        checkOutput("pause_halt_busy", busyA, 0);
        checkOutput("pause_halt_pc", pcA, 2);
        checkOutput("pause_halt_acc", accA, 0);
      end
      if (k == 11) checkOutput("pause_done_gone", doneA, 0);
      stepA = (k == 5) || (k == 9);
      applyStimulus(1'b0, 1'b0, 1'b0, (k == 9));
    end
    stepA = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
